// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the FFT stage sequencer slice.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_state_e;

    // Read-to-write latency through RAM read, butterfly and write-back.
    localparam int BF_PIPE_LAT  = 2;
    // Idle cycles between stages so the last write lands before the next read.
    localparam int DRAIN_CYCLES = 2;

    // Width of the stage index for a transform of 2^log2n points.
    function automatic int stage_w(input int log2n);
        return $clog2(log2n) + 1;
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: control and memory-side signals of the FFT sequencer.
// With FFT_SEQ_INVERSE_EN defined, the inverse/tw_conj pair is added.
interface fft_stage_sequencer_if
    import fft_pkg::*;
#(
    parameter int LOG2N = 4
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        rd_en;
    logic [LOG2N-1:0]            rd_addr_a;
    logic [LOG2N-1:0]            rd_addr_b;
    logic [LOG2N-2:0]            tw_addr;
    logic                        bf_en;
    logic                        wr_en;
    logic [LOG2N-1:0]            wr_addr_a;
    logic [LOG2N-1:0]            wr_addr_b;
    logic [stage_w(LOG2N)-1:0]   stage;
`ifdef FFT_SEQ_INVERSE_EN
    logic                        inverse;
    logic                        tw_conj;
`endif

    modport master (
`ifdef FFT_SEQ_INVERSE_EN
        input  inverse,
        output tw_conj,
`endif
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        output bf_en, wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
`ifdef FFT_SEQ_INVERSE_EN
        output inverse,
        input  tw_conj,
`endif
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
        input  bf_en, wr_en, wr_addr_a, wr_addr_b, stage
    );

endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// fft_addr_gen: combinational radix-2 DIT operand and twiddle address mapping
// for butterfly k of stage s.
module fft_addr_gen #(
    parameter int LOG2N = 4,
    parameter int SW    = fft_pkg::stage_w(LOG2N)
) (
    input  logic [SW-1:0]    s,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx
);
    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;

    // Group index moves up one bit to make room for the span bit; pos stays in place.
    always_comb begin
        k_ext  = {1'b0, k};
        span   = LOG2N'(1) << s;
        pos    = k_ext & (span - LOG2N'(1));
        addr_a = ((k_ext >> s) << (s + 1)) | pos;
        addr_b = addr_a | span;
        tw_idx = (LOG2N-1)'(pos << (LOG2N - 1 - s));
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: control engine for an in-place radix-2 DIT FFT held in a
// dual-port sample RAM. Optional build macro FFT_SEQ_INVERSE_EN adds the
// inverse request input and the tw_conj output.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_stage_sequencer_if.master bus
);
    localparam int HALF = 1 << (LOG2N - 1);
    localparam int KW   = LOG2N - 1;
    localparam int SW   = stage_w(LOG2N);
    localparam int DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] RUN   = ST_RUN;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]       state;
    logic [SW-1:0]    s;
    logic [KW-1:0]    k;
    logic [DW-1:0]    dcnt;
    logic             run;
    logic             busy;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [KW-1:0]    gen_tw;

    logic             vld_p1;
    logic             vld_p2;
    logic [LOG2N-1:0] addr_a_p1;
    logic [LOG2N-1:0] addr_b_p1;
    logic [LOG2N-1:0] addr_a_p2;
    logic [LOG2N-1:0] addr_b_p2;

    fft_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .s      (s),
        .k      (k),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Stage/butterfly sequencing: one butterfly per RUN cycle, fixed drain between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            k     <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                        s     <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    if (k == KW'(HALF - 1)) begin
                        state <= DRAIN;
                        dcnt  <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
                        if (s == SW'(LOG2N - 1)) begin
                            state <= DONE;
                        end else begin
                            state <= RUN;
                            s     <= s + SW'(1);
                            k     <= '0;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    s     <= '0;
                end
            endcase
        end
    end

    assign run  = (state == RUN);
    assign busy = run || (state == DRAIN);

    assign bus.busy      = busy;
    assign bus.done      = (state == DONE);
    assign bus.rd_en     = run;
    assign bus.rd_addr_a = run ? gen_a  : '0;
    assign bus.rd_addr_b = run ? gen_b  : '0;
    assign bus.tw_addr   = run ? gen_tw : '0;
    assign bus.stage     = s;

    // Read addresses follow the butterfly through RAM read (p1) and compute (p2).
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            addr_a_p2 <= '0;
            addr_b_p2 <= '0;
        end else begin
            vld_p1 <= run;
            vld_p2 <= vld_p1;
            if (run) begin
                addr_a_p1 <= gen_a;
                addr_b_p1 <= gen_b;
            end
            if (vld_p1) begin
                addr_a_p2 <= addr_a_p1;
                addr_b_p2 <= addr_b_p1;
            end
        end
    end

    assign bus.bf_en     = vld_p1;
    assign bus.wr_en     = vld_p2;
    assign bus.wr_addr_a = addr_a_p2;
    assign bus.wr_addr_b = addr_b_p2;

`ifdef FFT_SEQ_INVERSE_EN
    logic inv;

    // Direction is captured only at an accepted start and dropped while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inv <= 1'b0;
        end else if (state == IDLE) begin
            inv <= bus.start & bus.inverse;
        end
    end

    assign bus.tw_conj = inv & busy;
`endif

endmodule
